// File: rtl/counter_step_tracker_if.sv
// ============================================================================
// Module      : counter_step_tracker_if
// Description : Sample stream in / recovered counter mode out bundle for the
//               counter step tracker. The master drives samples, the slave
//               (the tracker) returns the recovered mode and error status.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface counter_step_tracker_if #(
  parameter int WIDTH = 4,
  parameter int ERR_W = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] cnt;
  logic             locked;
  logic             down;
  logic             step;
  logic [WIDTH-1:0] pred;
  logic             err;
  logic [ERR_W-1:0] err_count;

  modport master (
    output in_valid, cnt,
    input  locked, down, step, pred, err, err_count
  );

  modport slave (
    input  in_valid, cnt,
    output locked, down, step, pred, err, err_count
  );
endinterface

`default_nettype wire

// File: rtl/counter_step_tracker.sv
// ============================================================================
// Module      : counter_step_tracker
// Description : Watches the value stream of an up/down counter, infers its
//               direction and step size (1 or 2), locks after LOCK_LEN
//               consistent transitions, predicts the next value and counts
//               mismatches seen while locked (saturating).
// Options     : COUNTER_TRACK_STALL_EN - when defined, a repeated value is
//               tolerated in every state; otherwise it breaks track/lock.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_step_tracker #(
  parameter int WIDTH    = 4,
  parameter int LOCK_LEN = 3,
  parameter int ERR_W    = 8
) (
  input  wire logic              clk,
  input  wire logic              rst,
  counter_step_tracker_if.slave  bus
);

`ifdef COUNTER_TRACK_STALL_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  // Run counter only needs to reach LOCK_LEN; it never counts past it.
  localparam int               RUN_W    = (LOCK_LEN < 2) ? 1 : $clog2(LOCK_LEN + 1);
  localparam logic [RUN_W-1:0] LOCK_RUN = RUN_W'(LOCK_LEN);
  localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);
  // With LOCK_LEN = 1 a single legal transition is already enough to lock.
  localparam bit               LOCK_ON_FIRST = (LOCK_LEN <= 1);

  localparam logic [WIDTH-1:0] D_ONE   = WIDTH'(1);
  localparam logic [WIDTH-1:0] D_TWO   = WIDTH'(2);
  localparam logic [WIDTH-1:0] D_MONE  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] D_MTWO  = {{(WIDTH-1){1'b1}}, 1'b0};
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_SEED  = 2'd1,
    ST_TRACK = 2'd2,
    ST_LOCK  = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    CD_UP1     = 3'd0,
    CD_UP2     = 3'd1,
    CD_DN1     = 3'd2,
    CD_DN2     = 3'd3,
    CD_STALL   = 3'd4,
    CD_ILLEGAL = 3'd5
  } code_t;

  state_t           state;
  logic [WIDTH-1:0] prev;
  logic             cand_down;
  logic             cand_step;
  logic [RUN_W-1:0] run;

  logic             locked_r;
  logic             down_r;
  logic             step_r;
  logic [WIDTH-1:0] pred_r;
  logic             err_r;
  logic [ERR_W-1:0] err_count_r;

  logic [WIDTH-1:0] delta;
  code_t            code;
  logic             code_legal;
  logic             code_stall;
  logic             code_down;
  logic             code_step;
  logic             code_match;
  logic [WIDTH-1:0] step_amt;
  logic [WIDTH-1:0] pred_code;
  logic [RUN_W-1:0] run_inc;
  logic [ERR_W-1:0] err_count_inc;

  // Classify the transition from the previous sample and precompute the
  // prediction that follows the current sample under that transition.
  always_comb begin
    delta = bus.cnt - prev;
    code  = CD_ILLEGAL;
    if (delta == {WIDTH{1'b0}}) begin
      code = CD_STALL;
    end else if (delta == D_ONE) begin
      code = CD_UP1;
    end else if (delta == D_TWO) begin
      code = CD_UP2;
    end else if (delta == D_MONE) begin
      code = CD_DN1;
    end else if (delta == D_MTWO) begin
      code = CD_DN2;
    end

    code_legal = (code == CD_UP1) || (code == CD_UP2) ||
                 (code == CD_DN1) || (code == CD_DN2);
    code_stall = (code == CD_STALL);
    code_down  = (code == CD_DN1) || (code == CD_DN2);
    code_step  = (code == CD_UP2) || (code == CD_DN2);
    code_match = code_legal && (code_down == cand_down) && (code_step == cand_step);

    step_amt  = code_step ? D_TWO : D_ONE;
    pred_code = code_down ? (bus.cnt - step_amt) : (bus.cnt + step_amt);

    run_inc       = run + RUN_ONE;
    err_count_inc = (err_count_r == ERR_MAX) ? err_count_r : (err_count_r + ERR_W'(1));
  end

  // Tracker state machine with registered mode, prediction and error outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_EMPTY;
      prev        <= '0;
      cand_down   <= 1'b0;
      cand_step   <= 1'b0;
      run         <= '0;
      locked_r    <= 1'b0;
      down_r      <= 1'b0;
      step_r      <= 1'b0;
      pred_r      <= '0;
      err_r       <= 1'b0;
      err_count_r <= '0;
    end else begin
      err_r <= 1'b0;
      if (bus.in_valid) begin
        prev <= bus.cnt;
        case (state)
          ST_EMPTY: begin
            state <= ST_SEED;
          end

          ST_SEED: begin
            // First legal transition becomes the candidate mode.
            if (code_legal) begin
              cand_down <= code_down;
              cand_step <= code_step;
              run       <= RUN_ONE;
              if (LOCK_ON_FIRST) begin
                state    <= ST_LOCK;
                locked_r <= 1'b1;
                down_r   <= code_down;
                step_r   <= code_step;
                pred_r   <= pred_code;
              end else begin
                state <= ST_TRACK;
              end
            end
          end

          ST_TRACK: begin
            if (code_match) begin
              run <= run_inc;
              if (run_inc == LOCK_RUN) begin
                state    <= ST_LOCK;
                locked_r <= 1'b1;
                down_r   <= code_down;
                step_r   <= code_step;
                pred_r   <= pred_code;
              end
            end else if (code_legal) begin
              // A new legal mode restarts the consistency run.
              cand_down <= code_down;
              cand_step <= code_step;
              run       <= RUN_ONE;
              if (LOCK_ON_FIRST) begin
                state    <= ST_LOCK;
                locked_r <= 1'b1;
                down_r   <= code_down;
                step_r   <= code_step;
                pred_r   <= pred_code;
              end
            end else if (code_stall && STALL_EN) begin
              // Repeated value tolerated: hold everything.
            end else begin
              state <= ST_SEED;
              run   <= '0;
            end
          end

          ST_LOCK: begin
            if (code_match) begin
              pred_r <= pred_code;
            end else if (code_legal) begin
              // Mode change: flag it and start tracking the new mode.
              err_r       <= 1'b1;
              err_count_r <= err_count_inc;
              cand_down   <= code_down;
              cand_step   <= code_step;
              run         <= RUN_ONE;
              if (LOCK_ON_FIRST) begin
                down_r <= code_down;
                step_r <= code_step;
                pred_r <= pred_code;
              end else begin
                state    <= ST_TRACK;
                locked_r <= 1'b0;
                down_r   <= 1'b0;
                step_r   <= 1'b0;
                pred_r   <= '0;
              end
            end else if (code_stall && STALL_EN) begin
              // Repeated value tolerated: hold lock and outputs.
            end else begin
              err_r       <= 1'b1;
              err_count_r <= err_count_inc;
              state       <= ST_SEED;
              run         <= '0;
              locked_r    <= 1'b0;
              down_r      <= 1'b0;
              step_r      <= 1'b0;
              pred_r      <= '0;
            end
          end

          default: begin
            state <= ST_EMPTY;
          end
        endcase
      end
    end
  end

  assign bus.locked    = locked_r;
  assign bus.down      = down_r;
  assign bus.step      = step_r;
  assign bus.pred      = pred_r;
  assign bus.err       = err_r;
  assign bus.err_count = err_count_r;

endmodule

`default_nettype wire

// File: tb/tb_counter_step_tracker.sv
// ============================================================================
// Module      : tb_counter_step_tracker
// Description : Self-checking bench for counter_step_tracker: directed
//               sequences with literal expectations plus randomized streams
//               compared every cycle against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_counter_step_tracker;
  localparam int W    = 4;
  localparam int L    = 3;
  localparam int EW   = 8;
  localparam int MASK = (1 << W) - 1;
  localparam int EMAX = (1 << EW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  counter_step_tracker_if #(.WIDTH(W), .ERR_W(EW)) bus ();

  counter_step_tracker #(.WIDTH(W), .LOCK_LEN(L), .ERR_W(EW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  bit check_en = 1'b0;

`ifdef COUNTER_TRACK_STALL_EN
  localparam bit STALL_OK = 1'b1;
`else
  localparam bit STALL_OK = 1'b0;
`endif

  // Behavioural model: phase 0 = no sample yet, 1 = waiting for a legal
  // transition, 2 = following mode m_mode (signed step) for m_run transitions.
  // Locked simply means the run has reached L.
  int m_phase, m_prev, m_mode, m_run;
  int e_locked, e_down, e_step, e_pred, e_err, e_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    int d, m;
    bit legal, was_locked;
    if (rst) begin
      m_phase = 0; m_prev = 0; m_mode = 0; m_run = 0;
      e_err = 0; e_cnt = 0;
    end else if (!bus.in_valid) begin
      e_err = 0;
    end else begin
      e_err = 0;
      d = (int'(bus.cnt) - m_prev) & MASK;
      legal = (d == 1) || (d == 2) || (d == MASK) || (d == MASK - 1);
      m = (d > MASK / 2) ? d - (MASK + 1) : d;
      if (m_phase == 0) begin
        m_phase = 1;
      end else if (m_phase == 1) begin
        if (legal) begin m_mode = m; m_run = 1; m_phase = 2; end
      end else begin
        was_locked = (m_run >= L);
        if (d == 0 && STALL_OK) begin
          // tolerated
        end else if (!legal) begin
          e_err = was_locked ? 1 : 0; m_phase = 1; m_run = 0;
        end else if (m == m_mode) begin
          m_run++;
        end else begin
          e_err = was_locked ? 1 : 0; m_mode = m; m_run = 1;
        end
      end
      m_prev = int'(bus.cnt);
      if (e_err != 0 && e_cnt < EMAX) e_cnt++;
    end
    e_locked = (m_phase == 2 && m_run >= L) ? 1 : 0;
    e_down   = (e_locked != 0 && m_mode < 0) ? 1 : 0;
    e_step   = (e_locked != 0 && (m_mode == 2 || m_mode == -2)) ? 1 : 0;
    e_pred   = (e_locked != 0) ? ((m_prev + m_mode + MASK + 1) & MASK) : 0;
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (check_en) begin
      chk("m_locked",    32'(bus.locked),    32'(e_locked));
      chk("m_down",      32'(bus.down),      32'(e_down));
      chk("m_step",      32'(bus.step),      32'(e_step));
      chk("m_pred",      32'(bus.pred),      32'(e_pred));
      chk("m_err",       32'(bus.err),       32'(e_err));
      chk("m_err_count", 32'(bus.err_count), 32'(e_cnt));
    end
  end

  task automatic apply(input logic r, input logic v, input int c);
    rst          = r;
    bus.in_valid = v;
    bus.cnt      = W'(c & MASK);
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int start, input int delta, input int n);
    for (int i = 0; i < n; i++) apply(1'b0, 1'b1, start + i * delta);
  endtask

  task automatic do_reset();
    apply(1'b1, 1'b0, 0);
  endtask

  initial begin
    int v, dir, r, mode, stim_last, p;
    bus.in_valid = 1'b0;
    bus.cnt      = '0;
    do_reset();
    check_en = 1'b1;
    do_reset();
    chk("rst_locked", 32'(bus.locked), 0);
    chk("rst_pred",   32'(bus.pred), 0);
    chk("rst_errcnt", 32'(bus.err_count), 0);

    // Up by 1 from 0
    feed(0, 1, 4);
    chk("up1_locked", 32'(bus.locked), 1);
    chk("up1_down",   32'(bus.down), 0);
    chk("up1_step",   32'(bus.step), 0);
    chk("up1_pred",   32'(bus.pred), 4);
    chk("up1_err",    32'(bus.err), 0);

    // Down by 2 across the wrap
    do_reset();
    feed(2, -2, 4);
    chk("dn2_locked", 32'(bus.locked), 1);
    chk("dn2_down",   32'(bus.down), 1);
    chk("dn2_step",   32'(bus.step), 1);
    chk("dn2_pred",   32'(bus.pred), 10);

    // Illegal jump while locked, then relock
    do_reset();
    feed(2, 1, 4);
    apply(1'b0, 1'b1, 9);
    chk("jump_err",    32'(bus.err), 1);
    chk("jump_errcnt", 32'(bus.err_count), 1);
    chk("jump_locked", 32'(bus.locked), 0);
    apply(1'b0, 1'b0, 0);
    chk("jump_err_pulse", 32'(bus.err), 0);
    feed(10, 1, 4);
    chk("relock_locked", 32'(bus.locked), 1);
    chk("relock_pred",   32'(bus.pred), 14);

    // Direction reversal
    do_reset();
    feed(4, 1, 4);
    apply(1'b0, 1'b1, 6);
    chk("rev_err", 32'(bus.err), 1);
    apply(1'b0, 1'b1, 5);
    apply(1'b0, 1'b1, 4);
    chk("rev_locked", 32'(bus.locked), 1);
    chk("rev_down",   32'(bus.down), 1);
    chk("rev_step",   32'(bus.step), 0);
    chk("rev_errcnt", 32'(bus.err_count), 1);

    // Reset mid-lock clears everything including the error count
    apply(1'b1, 1'b1, 3);
    chk("midrst_locked", 32'(bus.locked), 0);
    chk("midrst_down",   32'(bus.down), 0);
    chk("midrst_pred",   32'(bus.pred), 0);
    chk("midrst_errcnt", 32'(bus.err_count), 0);

    // Stall while locked
    do_reset();
    feed(0, 1, 4);
    apply(1'b0, 1'b1, 3);
    chk("stall_locked", 32'(bus.locked), STALL_OK ? 1 : 0);
    chk("stall_err",    32'(bus.err), STALL_OK ? 0 : 1);

    // Gaps between samples do not change the outcome
    do_reset();
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 1'b1, i);
      apply(1'b0, 1'b0, int'($urandom_range(0, MASK)));
    end
    chk("gap_locked", 32'(bus.locked), 1);
    chk("gap_pred",   32'(bus.pred), 4);
    chk("gap_err",    32'(bus.err), 0);

    // 300 mode changes while locked saturate the error counter
    do_reset();
    feed(0, 1, 4);
    v = 3; dir = 1;
    for (int k = 0; k < 300; k++) begin
      dir = -dir;
      for (int j = 0; j < 3; j++) begin
        v = (v + dir) & MASK;
        apply(1'b0, 1'b1, v);
      end
    end
    chk("sat_errcnt", 32'(bus.err_count), EMAX);
    chk("sat_locked", 32'(bus.locked), 1);

    // Randomized stream with mostly consistent mode, stalls, jumps, resets
    do_reset();
    stim_last = 0; mode = 1;
    for (int n = 0; n < 4000; n++) begin
      r = int'($urandom_range(0, 199));
      if (r < 2) begin
        apply(1'b1, 1'($urandom_range(0, 1)), stim_last);
      end else if (r < 50) begin
        apply(1'b0, 1'b0, int'($urandom_range(0, MASK)));
      end else begin
        if ($urandom_range(0, 99) < 5) begin
          case ($urandom_range(0, 3))
            0: mode = 1;
            1: mode = 2;
            2: mode = -1;
            default: mode = -2;
          endcase
        end
        p = int'($urandom_range(0, 99));
        if (p < 85)      stim_last = (stim_last + mode + MASK + 1) & MASK;
        else if (p < 92) stim_last = stim_last;
        else             stim_last = int'($urandom_range(0, MASK));
        apply(1'b0, 1'b1, stim_last);
      end
    end

    apply(1'b0, 1'b0, 0);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

`default_nettype wire
